// File: rtl/axi_burst_writer_pkg.sv
// axi_pkg: AXI4 burst/response encodings and the AWSIZE helper shared by the burst writer
package axi_pkg;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  function automatic logic [2:0] axi_size_f(input int bytes);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) if ((1 << i) == bytes) s = 3'(i);
    return s;
  endfunction
endpackage

// File: rtl/axi_burst_writer_if.sv
// axi_burst_writer_if: AXI4 write-channel bundle (AW/W/B) with master and slave views
interface axi_burst_writer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [7:0] M_AXI_AWLEN;
  logic [2:0] M_AXI_AWSIZE;
  logic [1:0] M_AXI_AWBURST;
  logic M_AXI_AWVALID;
  logic M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic M_AXI_WLAST;
  logic M_AXI_WVALID;
  logic M_AXI_WREADY;
  logic [1:0] M_AXI_BRESP;
  logic M_AXI_BVALID;
  logic M_AXI_BREADY;
  modport master (
    output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
    input M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );
  modport slave (
    input M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    input M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );
endinterface

// File: rtl/axi_burst_len_calc.sv
// axi_burst_len_calc: next burst length = min(remaining, MAX_BURST[, beats to 4 KB boundary])
// 4 KB splitting is enabled by defining AXI_BURST_WRITER_4K_SPLIT_EN.
module axi_burst_len_calc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST = 16,
  parameter int LEN_WIDTH = 16
) (
  input logic [ADDR_WIDTH-1:0] addr,
  input logic [LEN_WIDTH-1:0] remaining,
  output logic [8:0] len
);
  localparam int SIZE = $clog2(DATA_WIDTH / 8);
  logic [8:0] cap;
  assign cap = (remaining > LEN_WIDTH'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(remaining);
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
  logic [12:0] room;
  logic unused_addr;
  assign room = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE;
  assign len = ({4'b0, cap} > room) ? room[8:0] : cap;
  assign unused_addr = ^addr[ADDR_WIDTH-1:12];
`else
  logic unused_addr;
  assign len = cap;
  assign unused_addr = ^addr;
`endif
endmodule

// File: rtl/axi_burst_writer.sv
// axi_burst_writer: one command (addr, beats) -> sequence of AXI4 INCR write bursts, one outstanding.
// Define AXI_BURST_WRITER_4K_SPLIT_EN to keep every burst inside a 4 KB page.
module axi_burst_writer
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST = 16,
  parameter int LEN_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [ADDR_WIDTH-1:0] cmd_addr,
  input logic [LEN_WIDTH-1:0] cmd_beats,
  output logic busy,
  output logic done,
  output logic error,
  input logic [DATA_WIDTH-1:0] s_wdata,
  input logic s_wvalid,
  output logic s_wready,
  axi_burst_writer_if.master m_axi
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE = axi_size_f(BYTES);
  typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [LEN_WIDTH-1:0] rem_q, rem_n;
  logic [8:0] len_q, len_c, cnt_q;
  logic err_q, go, w_hs, b_hs, b_err;
  assign go = state == IDLE && start;
  assign w_hs = state == W && s_wvalid && m_axi.M_AXI_WREADY;
  assign b_hs = state == B && m_axi.M_AXI_BVALID;
  assign b_err = m_axi.M_AXI_BRESP != AXI_RESP_OKAY;
  // addr/remaining for the burst about to be issued, from the command or after the current one
  assign addr_n = state == IDLE ? cmd_addr & ~ADDR_WIDTH'(BYTES - 1)
                                : addr_q + (ADDR_WIDTH'(len_q) << SIZE);
  assign rem_n = state == IDLE ? cmd_beats : rem_q - LEN_WIDTH'(len_q);
  axi_burst_len_calc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST(MAX_BURST),
    .LEN_WIDTH(LEN_WIDTH)
  ) u_len (
    .addr(addr_n),
    .remaining(rem_n),
    .len(len_c)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = cmd_beats == '0 ? DONE : AW;
      AW: if (m_axi.M_AXI_AWREADY) state_n = W;
      W: if (w_hs && cnt_q == 9'd1) state_n = B;
      B: if (b_hs) state_n = (b_err || rem_n == '0) ? DONE : AW;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (go) err_q <= 1'b0;
      if (b_hs && b_err) err_q <= 1'b1;
      if ((go && cmd_beats != '0) || (b_hs && !b_err)) begin
        addr_q <= addr_n;
        rem_q <= rem_n;
        len_q <= len_c;
      end
      if (state == AW && m_axi.M_AXI_AWREADY) cnt_q <= len_q;
      else if (w_hs) cnt_q <= cnt_q - 9'd1;
    end
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    error = err_q;
    s_wready = state == W && m_axi.M_AXI_WREADY;
    m_axi.M_AXI_AWVALID = state == AW;
    m_axi.M_AXI_AWADDR = state == AW ? addr_q : '0;
    m_axi.M_AXI_AWLEN = state == AW ? 8'(len_q - 9'd1) : '0;
    m_axi.M_AXI_WVALID = state == W && s_wvalid;
    m_axi.M_AXI_WLAST = state == W && cnt_q == 9'd1;
    m_axi.M_AXI_BREADY = state == B;
  end
  assign m_axi.M_AXI_AWSIZE = SIZE;
  assign m_axi.M_AXI_AWBURST = AXI_BURST_INCR;
  assign m_axi.M_AXI_WDATA = s_wdata;
  assign m_axi.M_AXI_WSTRB = '1;
endmodule

// File: tb/tb_axi_burst_writer.sv
// tb_axi_burst_writer: scoreboard bench with a reactive AXI slave and data-stream source
module tb_axi_burst_writer;
  import axi_pkg::*;
  localparam int AW = 32, DW = 64, MB = 16, LW = 16;
  logic clk = 0, rst = 1, start = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_beats = '0;
  logic busy, done, error, s_wvalid, s_wready;
  logic [DW-1:0] s_wdata;
  axi_burst_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  axi_burst_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .busy(busy), .done(done), .error(error), .s_wdata(s_wdata), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .m_axi(bus)
  );
  always #5 clk = ~clk;
  typedef struct {logic [AW-1:0] addr; logic [7:0] len;} aw_t;
  typedef struct {logic [DW-1:0] data; logic last;} w_t;
  aw_t exp_aw[$];
  w_t exp_w[$];
  logic [DW-1:0] src_q[$];
  int checks = 0, errors = 0;
  int done_cnt = 0, awv_cycles = 0, aw_unstable = 0, aw_cnt = 0, w_cnt = 0;
  int b_idx = 0, bad_idx = -1, pending_b = 0;
  bit stall = 0;
  // Slave + source driver and output monitor: sample at negedge, react just after posedge
  initial begin
    bit aw_hs, w_hs, b_hs, aw_held;
    aw_t prev, ea;
    w_t ew;
    aw_held = 0;
    bus.M_AXI_AWREADY = 0;
    bus.M_AXI_WREADY = 0;
    bus.M_AXI_BVALID = 0;
    bus.M_AXI_BRESP = AXI_RESP_OKAY;
    s_wvalid = 0;
    s_wdata = '0;
    forever begin
      @(negedge clk);
      aw_hs = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
      w_hs = s_wvalid && s_wready;
      b_hs = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
      if (rst) begin
        aw_hs = 0;
        w_hs = 0;
        b_hs = 0;
        aw_held = 0;
        pending_b = 0;
        bus.M_AXI_BVALID = 0;
      end
      if (bus.M_AXI_AWVALID) awv_cycles++;
      if (bus.M_AXI_AWVALID && aw_held && (bus.M_AXI_AWADDR !== prev.addr || bus.M_AXI_AWLEN !== prev.len))
        aw_unstable++;
      aw_held = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
      prev = '{bus.M_AXI_AWADDR, bus.M_AXI_AWLEN};
      if (done) done_cnt++;
      if (aw_hs) begin
        aw_cnt++;
        checks++;
        if (exp_aw.size() == 0) begin
          errors++;
          $display("FAIL aw_unexpected: got addr=%h len=%0d, required no burst", bus.M_AXI_AWADDR, bus.M_AXI_AWLEN);
        end else begin
          ea = exp_aw.pop_front();
          if (bus.M_AXI_AWADDR !== ea.addr || bus.M_AXI_AWLEN !== ea.len) begin
            errors++;
            $display("FAIL aw_burst: got addr=%h len=%0d, required addr=%h len=%0d",
                     bus.M_AXI_AWADDR, bus.M_AXI_AWLEN, ea.addr, ea.len);
          end
        end
      end
      if (w_hs) begin
        w_cnt++;
        checks++;
        if (exp_w.size() == 0) begin
          errors++;
          $display("FAIL w_unexpected: got data=%h, required no beat", bus.M_AXI_WDATA);
        end else begin
          ew = exp_w.pop_front();
          if (bus.M_AXI_WDATA !== ew.data || bus.M_AXI_WLAST !== ew.last || bus.M_AXI_WVALID !== 1'b1) begin
            errors++;
            $display("FAIL w_beat: got data=%h last=%b valid=%b, required data=%h last=%b valid=1",
                     bus.M_AXI_WDATA, bus.M_AXI_WLAST, bus.M_AXI_WVALID, ew.data, ew.last);
          end
        end
        if (bus.M_AXI_WLAST) pending_b++;
      end
      @(posedge clk);
      #1;
      if (b_hs) begin
        bus.M_AXI_BVALID = 0;
        b_idx++;
      end
      if (w_hs && src_q.size() > 0) void'(src_q.pop_front());
      bus.M_AXI_AWREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.M_AXI_WREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_wvalid = src_q.size() > 0 && (!stall || $urandom_range(0, 2) != 0);
      s_wdata = src_q.size() > 0 ? src_q[0] : '0;
      if (!bus.M_AXI_BVALID && pending_b > 0 && (!stall || $urandom_range(0, 1) == 1)) begin
        bus.M_AXI_BVALID = 1;
        bus.M_AXI_BRESP = b_idx == bad_idx ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        pending_b--;
      end
    end
  end
  task automatic expect_cmd(input logic [AW-1:0] a, input int beats);
    int rem, n;
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    rem = beats;
    addr = a & ~AW'(DW / 8 - 1);
    while (rem > 0) begin
      n = rem > MB ? MB : rem;
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
      if (n > (4096 - int'(addr[11:0])) / (DW / 8)) n = (4096 - int'(addr[11:0])) / (DW / 8);
`endif
      exp_aw.push_back('{addr, 8'(n - 1)});
      for (int i = 0; i < n; i++) begin
        d = {$urandom, $urandom};
        exp_w.push_back('{d, i == n - 1});
        src_q.push_back(d);
      end
      addr = addr + AW'(n * (DW / 8));
      rem -= n;
    end
  endtask
  task automatic issue(input logic [AW-1:0] a, input int beats);
    @(posedge clk);
    #1;
    cmd_addr = a;
    cmd_beats = LW'(beats);
    done_cnt = 0;
    awv_cycles = 0;
    aw_unstable = 0;
    aw_cnt = 0;
    w_cnt = 0;
    b_idx = 0;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask
  task automatic flush();
    exp_aw.delete();
    exp_w.delete();
    src_q.delete();
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, error, s_wready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_status: got busy/done/error/s_wready=%b, required 0000", {busy, done, error, s_wready});
    end
    checks++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST, bus.M_AXI_BREADY, bus.M_AXI_AWLEN} !== 12'b0) begin
      errors++;
      $display("FAIL reset_axi: got awv/wv/wlast/bready=%b awlen=%0d, required all 0",
               {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WLAST, bus.M_AXI_BREADY}, bus.M_AXI_AWLEN);
    end
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic test_basic();
    bit ok;
    expect_cmd(32'h1000, 40);
    issue(32'h1000, 40);
    @(negedge clk);
    checks++;
    if (bus.M_AXI_AWVALID !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: got awvalid=%b busy=%b at t+1, required 1 1", bus.M_AXI_AWVALID, busy);
    end
    checks++;
    if (bus.M_AXI_AWSIZE !== 3'd3 || bus.M_AXI_AWBURST !== AXI_BURST_INCR || bus.M_AXI_WSTRB !== 8'hFF) begin
      errors++;
      $display("FAIL basic_const: got size=%0d burst=%b strb=%h, required 3 01 ff",
               bus.M_AXI_AWSIZE, bus.M_AXI_AWBURST, bus.M_AXI_WSTRB);
    end
    wait_done(500, ok);
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: got done_seen=%0d busy=%b, required 1 1", ok, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got busy=%b done=%b after done, required 0 0", busy, done);
    end
    checks++;
    if (w_cnt != 40 || aw_cnt != 3 || done_cnt != 1 || error !== 1'b0 || exp_w.size() != 0) begin
      errors++;
      $display("FAIL basic_totals: got w=%0d aw=%0d done=%0d error=%b left=%0d, required 40 3 1 0 0",
               w_cnt, aw_cnt, done_cnt, error, exp_w.size());
    end
  endtask
  task automatic test_split();
    bit ok;
    int bursts;
`ifdef AXI_BURST_WRITER_4K_SPLIT_EN
    bursts = 2;
`else
    bursts = 1;
`endif
    expect_cmd(32'h0FF0, 8);
    issue(32'h0FF0, 8);
    wait_done(300, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || aw_cnt != bursts || w_cnt != 8 || exp_aw.size() != 0) begin
      errors++;
      $display("FAIL split_totals: got done_seen=%0d aw=%0d w=%0d left=%0d, required 1 %0d 8 0",
               ok, aw_cnt, w_cnt, exp_aw.size(), bursts);
    end
  endtask
  task automatic test_zero();
    issue(32'h4000, 0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || bus.M_AXI_AWVALID !== 1'b0) begin
      errors++;
      $display("FAIL zero_t1: got done=%b busy=%b awvalid=%b, required 1 1 0", done, busy, bus.M_AXI_AWVALID);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_t2: got done=%b busy=%b, required 0 0", done, busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (awv_cycles != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_traffic: got awvalid_cycles=%0d done=%0d, required 0 1", awv_cycles, done_cnt);
    end
  endtask
  task automatic test_stall();
    bit ok;
    stall = 1;
    expect_cmd(32'h8000, 33);
    issue(32'h8000, 33);
    wait_done(3000, ok);
    stall = 0;
    checks++;
    if (!ok || aw_unstable != 0) begin
      errors++;
      $display("FAIL stall_aw: got done_seen=%0d aw_changes=%0d, required 1 0", ok, aw_unstable);
    end
    checks++;
    if (w_cnt != 33 || aw_cnt != 3 || exp_w.size() != 0) begin
      errors++;
      $display("FAIL stall_totals: got w=%0d aw=%0d left=%0d, required 33 3 0", w_cnt, aw_cnt, exp_w.size());
    end
  endtask
  task automatic test_error();
    bit ok;
    bad_idx = 0;
    expect_cmd(32'h3000, 48);
    issue(32'h3000, 48);
    wait_done(500, ok);
    checks++;
    if (!ok || error !== 1'b1) begin
      errors++;
      $display("FAIL error_set: got done_seen=%0d error=%b, required 1 1", ok, error);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (aw_cnt != 1 || w_cnt != 16 || exp_aw.size() != 2 || bus.M_AXI_AWVALID !== 1'b0 || error !== 1'b1) begin
      errors++;
      $display("FAIL error_abort: got aw=%0d w=%0d pending_aw=%0d awvalid=%b error=%b, required 1 16 2 0 1",
               aw_cnt, w_cnt, exp_aw.size(), bus.M_AXI_AWVALID, error);
    end
    flush();
    bad_idx = -1;
    expect_cmd(32'h3000, 4);
    issue(32'h3000, 4);
    @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: got error=%b after new start, required 0", error);
    end
    wait_done(300, ok);
    checks++;
    if (!ok || w_cnt != 4 || error !== 1'b0) begin
      errors++;
      $display("FAIL error_rerun: got done_seen=%0d w=%0d error=%b, required 1 4 0", ok, w_cnt, error);
    end
  endtask
  task automatic test_reset_mid();
    bit ok;
    expect_cmd(32'h5000, 32);
    issue(32'h5000, 32);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.M_AXI_WVALID;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_reach_w: got wvalid=0 within 50 cycles, required 1");
    end
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, busy, s_wready} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_idle: got awv/wv/bready/busy/s_wready=%b, required 00000",
               {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, busy, s_wready});
    end
    flush();
    expect_cmd(32'h2000, 8);
    issue(32'h2000, 8);
    wait_done(300, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || w_cnt != 8 || aw_cnt != 1 || exp_w.size() != 0 || error !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_rerun: got done_seen=%0d w=%0d aw=%0d left=%0d error=%b, required 1 8 1 0 0",
               ok, w_cnt, aw_cnt, exp_w.size(), error);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_split();
    test_zero();
    test_stall();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1 ms, required finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_burst_writer.md
# axi_burst_writer

Parametrised AXI4 write-burst master that turns one command (start address plus beat count) into a sequence of INCR bursts. Write data comes from a valid/ready stream and passes through to the W channel. It generalises the fixed-width master stub: data width, maximum burst length and transfer length are parametrised, 4 KB-boundary splitting and write-response error reporting are added, and it is used by DMA and test-traffic engines on the system interconnect.

## Interface
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI data width; power of 2, 8..1024; BYTES = DATA_WIDTH/8.
- MAX_BURST, 16, maximum beats per burst; power of 2, 1..256.
- LEN_WIDTH, 16, width of the beat-count field.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  command strobe; accepted only in IDLE.
- cmd_addr  in  ADDR_WIDTH  start byte address; low log2(BYTES) bits forced to 0.
- cmd_beats  in  LEN_WIDTH  total beats; 0 is legal.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky; a non-OKAY BRESP was seen; cleared on an accepted start.
- s_wdata  in  DATA_WIDTH  write-data stream payload.
- s_wvalid  in  1  stream valid.
- s_wready  out  1  stream ready.
- M_AXI_AWADDR  out  ADDR_WIDTH  burst start address.
- M_AXI_AWLEN  out  8  beats-1.
- M_AXI_AWSIZE  out  3  log2(BYTES), constant.
- M_AXI_AWBURST  out  2  INCR (2'b01), constant.
- M_AXI_AWVALID  out  1  address valid.
- M_AXI_AWREADY  in  1  address ready.
- M_AXI_WDATA  out  DATA_WIDTH  combinational copy of s_wdata.
- M_AXI_WSTRB  out  BYTES  all ones.
- M_AXI_WLAST  out  1  high on the last beat of each burst.
- M_AXI_WVALID  out  1  s_wvalid gated by the W state.
- M_AXI_WREADY  in  1  data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  response valid.
- M_AXI_BREADY  out  1  high only in the B state.

## Operation
- FSM states: IDLE, AW, W, B, DONE.
- IDLE + start:
  - cmd_beats=0 → DONE, and no AXI traffic is generated.
  - otherwise latch addr and remaining = cmd_beats, clear error, → AW.
- AW: burst length = min(remaining, MAX_BURST, beats to the 4 KB boundary when splitting is enabled).
  - AWVALID=1; AWADDR and AWLEN are registered and held stable until AWREADY.
  - On the AW handshake → W; the beat counter loads the burst length.
- W: s_wready = M_AXI_WREADY and M_AXI_WVALID = s_wvalid.
  - Each W handshake decrements the beat counter.
  - WLAST is high when the counter is 1.
  - The WLAST handshake → B.
- B: BREADY=1. On the B handshake:
  - if BRESP != OKAY, set error, → DONE; remaining bursts are aborted.
  - otherwise addr += len*BYTES (modulo 2^ADDR_WIDTH) and remaining -= len.
  - then → DONE if remaining = 0, else → AW.
- DONE: done=1 for one cycle, then → IDLE. A start in DONE is ignored.
- Only one burst is outstanding at a time. W never precedes its AW handshake.

## Timing
- Reset values: state IDLE; every output is 0, including error (gated outputs read 0).
- start accepted at cycle t → AWVALID=1 at t+1; busy=1 from t+1.
- Zero-length command: done=1 at t+1.
- Final B handshake at cycle u → done=1 and busy=1 at u+1; busy=0 at u+2.
- An AW handshake moves to W with no dead cycle, so WVALID can be accepted on the next cycle.
- Reset mid-transfer: return to IDLE on the next edge and drop all valids. System-level reset must be coordinated with the slave.

## Configuration
- AXI_BURST_WRITER_4K_SPLIT_EN defined:
  - beats to the boundary = (4096 - addr[11:0]) / BYTES.
  - no burst crosses a 4 KB address boundary.
- Not defined:
  - bursts are cut only at MAX_BURST.
  - the caller guarantees that no burst crosses a 4 KB boundary.

## Structure
- Package axi_pkg holds:
  - AXI_BURST_FIXED/INCR/WRAP.
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - the axi_size_f(BYTES) function.
- The FSM state enum is local to the module.
- Sub-module axi_burst_len_calc is combinational. It takes addr, remaining and the parameters, and returns the burst length, including the 4 KB logic under the macro.

## Test plan
- DATA_WIDTH=64, MAX_BURST=16, addr 0x1000, 40 beats, always-ready slave → AWLEN 15, 15, 7 at 0x1000, 0x1080, 0x1100; 40 W beats; WLAST on beats 16/32/40; done once; error=0.
- With splitting enabled, addr 0x0FF0, 8 beats → bursts of 2 beats (0x0FF0) and 6 beats (0x1000). Without the macro → a single burst with AWLEN 7.
- cmd_beats=0 → done at t+1, no AWVALID, busy high for exactly one cycle.
- Random AWREADY/WREADY/s_wvalid stalls, 33 beats → AWADDR/AWLEN stable while AWVALID is high, data order preserved, total W beats = 33.
- BRESP=SLVERR on the first burst of a 3-burst command → error=1, done, no further AWVALID. A new start clears error.
- rst asserted during the W state → next cycle all valids 0 and busy 0; a subsequent start at 0x2000 completes normally.
